// File: rtl/imem_read_responder.sv
// Responder side of the fetch memory read interface: latched request, fixed access
// latency, byte-serial little-endian assembly from a loader-filled byte RAM.
module imem_read_responder #(
  parameter int unsigned MADDR_L = 32,
  parameter int unsigned DATA_L  = 32,
  parameter int unsigned MEM_AW  = 13,
  parameter int unsigned LAT     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_re,
  input  logic [MADDR_L-1:0] addr,
  input  logic [1:0]         m_rlen,
  output logic               m_rack,
  output logic [DATA_L-1:0]  dataout,
  output logic               m_err,
  input  logic               ld_we,
  input  logic [MEM_AW-1:0]  ld_addr,
  input  logic [7:0]         ld_data
);

  localparam int unsigned DEPTH  = 2 ** MEM_AW;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned SUM_W  = MEM_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  logic [7:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [1:0]          k_q, k_d;
  logic [1:0]          len_q, len_d;
  logic [MEM_AW-1:0]   base_q, base_d;
  logic                oor_q, oor_d;
  logic [DATA_L-1:0]   data_q, data_d;
  logic                rack_q, rack_d;
  logic                err_q, err_d;

  logic [SUM_W-1:0]    end_sum_c;
  logic                oor_c;
  logic [MEM_AW-1:0]   rd_addr_c;
  logic [7:0]          rd_byte_c;

  // Range check at capture: high address bits set, or last byte past the RAM top.
  assign end_sum_c = {1'b0, addr[MEM_AW-1:0]} + SUM_W'(m_rlen);
  assign oor_c     = (|addr[MADDR_L-1:MEM_AW]) | end_sum_c[MEM_AW];

  assign rd_addr_c = base_q + MEM_AW'(k_q);
  assign rd_byte_c = mem[rd_addr_c];

  // Loader write; the lane register samples the pre-write byte on a same-edge collision.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      k_q     <= '0;
      len_q   <= '0;
      base_q  <= '0;
      oor_q   <= 1'b0;
      data_q  <= '0;
      rack_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      k_q     <= k_d;
      len_q   <= len_d;
      base_q  <= base_d;
      oor_q   <= oor_d;
      data_q  <= data_d;
      rack_q  <= rack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    k_d     = k_q;
    len_d   = len_q;
    base_d  = base_q;
    oor_d   = oor_q;
    data_d  = data_q;
    rack_d  = rack_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (m_re) begin
          base_d = addr[MEM_AW-1:0];
          len_d  = m_rlen;
          oor_d  = oor_c;
          data_d = '0;
          k_d    = '0;
          if (LAT == 0) begin
            state_d = S_READ;
          end else begin
            state_d = S_WAIT;
            wait_d  = WAIT_W'(LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_READ;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_READ: begin
        // Out-of-range accesses keep the cleared (zero) assembly register.
        if (!oor_q) begin
          case (k_q)
            2'd0:    data_d[7:0]   = rd_byte_c;
            2'd1:    data_d[15:8]  = rd_byte_c;
            2'd2:    data_d[23:16] = rd_byte_c;
            default: data_d[31:24] = rd_byte_c;
          endcase
        end
        k_d = k_q + 2'd1;
        if (k_q == len_q) begin
          rack_d  = 1'b1;
          err_d   = oor_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!m_re) begin
          rack_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_rack  = rack_q;
  assign dataout = data_q;
  assign m_err   = err_q;

endmodule
